// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one SPI master transmit engine between N_REQ word producers.
//   Round-robin grant in IDLE; a grant is held for a multi-word burst that
//   ends on req_last (or when the owner drops req). Drives a per-requester
//   active-low chip select with SETUP_CYC setup and GAP_CYC inter-frame gap.
//
// Handshake: requester i holds req[i]=1 with its word on req_data/req_last
//   until ack[i] pulses for one cycle; on the following cycle it presents
//   the next word (or drops req). The SPI core sees a one-cycle spi_start
//   with spi_data valid in that cycle, reports spi_busy while shifting and
//   pulses spi_done once at the end of each word.
//
// Ports:
//   clk_100, a_rst_n      clock, asynchronous active-low reset
//   req/req_data/req_last requester side word-valid, word, last flag
//   ack                   one-cycle "word taken" pulse per requester
//   grant                 one-hot owner, 0 when idle
//   spi_start/spi_data    start pulse and word to the SPI core
//   spi_busy/spi_done     SPI core status
//   cs_n                  active-low chip selects (only granted bit low)
//   err                   WAIT watchdog pulse
//
// Optional build macro: SPI_ARB_TIMEOUT_EN enables the WAIT watchdog
//   (TIMEOUT_CYC cycles without spi_done abandons the burst and pulses err).
//   Without it err is tied to 0.
//
// The FSM state is kept in the signal 'state' (type state_t) so checkers can
// bind to it.
module spi_txn_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = 2,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk_100,
  input  logic                      a_rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          grant,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_data,
  input  logic                      spi_busy,
  input  logic                      spi_done,
  output logic [N_REQ-1:0]          cs_n,
  output logic                      err
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (N_REQ < 2 || N_REQ > 8 || SETUP_CYC < 1 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("spi_txn_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  g_idx, g_idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last_q, last_nxt;
  logic [N_REQ-1:0]  grant_nxt, ack_nxt;
  logic              start_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              end_burst;
  logic              timeout_hit;

  // Round-robin pick: first set req bit from ptr+1 upward, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(idx);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Counter is zero outside WAIT, so every entry into WAIT starts from 0.
  assign timeout_hit = (state == WAIT) && !spi_done &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (state == WAIT && !timeout_hit) to_cnt <= to_cnt + 1'b1;
      else                               to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    g_idx_nxt = g_idx;
    cnt_nxt   = cnt;
    last_nxt  = last_q;
    grant_nxt = grant;
    ack_nxt   = '0;
    start_nxt = 1'b0;
    data_nxt  = spi_data;
    end_burst = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          g_idx_nxt = sel_idx;
          grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
          cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) state_nxt = ISSUE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ISSUE: begin
        // Start/ack are registered, so they appear in the first WAIT cycle.
        if (!spi_busy) begin
          start_nxt      = 1'b1;
          data_nxt       = req_data[g_idx*DATA_W +: DATA_W];
          ack_nxt[g_idx] = 1'b1;
          last_nxt       = req_last[g_idx];
          state_nxt      = WAIT;
        end
      end
      WAIT: begin
        if (spi_done) begin
          // A dropped req without last also closes the burst.
          if (last_q || !req[g_idx]) end_burst = 1'b1;
          else                       state_nxt = ISSUE;
        end else if (timeout_hit) begin
          end_burst = 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (end_burst) begin
      state_nxt = GAP;
      grant_nxt = '0;
      ptr_nxt   = g_idx;
      cnt_nxt   = CNT_W'(GAP_CYC - 1);
    end
  end

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N_REQ - 1);
      g_idx     <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
      grant     <= '0;
      cs_n      <= '1;
      ack       <= '0;
      spi_start <= 1'b0;
      spi_data  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      g_idx     <= g_idx_nxt;
      cnt       <= cnt_nxt;
      last_q    <= last_nxt;
      grant     <= grant_nxt;
      cs_n      <= ~grant_nxt;
      ack       <= ack_nxt;
      spi_start <= start_nxt;
      spi_data  <= data_nxt;
    end
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one SPI master transmit engine between N_REQ requesters.
- Grants the engine round-robin and holds a grant for a multi-word burst terminated by a last flag.
- Drives a per-requester active-low chip select with setup and inter-frame gap timing.
- Sits between user-side word producers (button/test logic, sequencers) and the SPI core's start/data/busy/done interface.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, SPI word width.
- SETUP_CYC, 2, clocks with cs_n low before the first spi_start of a burst (>=1).
- GAP_CYC, 4, clocks with all cs_n high after a burst ends (>=1).
- TIMEOUT_CYC, 1024, WAIT watchdog limit. Used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk_100  in  1  system clock, 100 MHz.
- a_rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester word-valid, level.
- req_data  in  N_REQ*DATA_W  requester i's word at bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  word presented is the last of the burst.
- ack  out  N_REQ  one-cycle pulse: word taken. Requester advances data/last on the next cycle.
- grant  out  N_REQ  one-hot owner of the engine, 0 when idle.
- spi_start  out  1  one-cycle start pulse to the SPI core.
- spi_data  out  DATA_W  word to the SPI core, valid while spi_start=1.
- spi_busy  in  1  SPI core shifting.
- spi_done  in  1  SPI core one-cycle end-of-word pulse.
- cs_n  out  N_REQ  active-low chip selects; only the granted bit may be low.
- err  out  1  timeout pulse (0 without the macro).

Behaviour:
- Reset (async, a_rst_n=0):
  - state=IDLE.
  - grant, ack, spi_start, spi_data and err are all 0; cs_n is all 1.
  - The round-robin pointer is N_REQ-1, so requester 0 has first priority.
- Round-robin selection: choose the first set req bit searching from pointer+1 upward, with wrap-around. The pointer is updated to the granted index when the burst ends.
- IDLE: if any req is set, register the grant, drive cs_n[g]=0, load the counter with SETUP_CYC-1, go to SETUP. Arbitration happens only in IDLE. A requester arriving mid-burst waits.
- SETUP: count down; at 0, go to ISSUE.
- ISSUE:
  - If spi_busy=1, stall in ISSUE with no pulse.
  - Otherwise, in the same cycle: spi_start=1, spi_data=req_data[g], ack[g]=1, latch req_last[g]; then go to WAIT.
- WAIT: on spi_done:
  - If the latched last=1, go to GAP.
  - Otherwise, if req[g]=1, go to ISSUE. Back-to-back words keep cs_n low, with one idle cycle between done and the next start.
  - Otherwise (req dropped without last), go to GAP; the burst is treated as ended.
- GAP: grant=0 and cs_n all 1. Count GAP_CYC cycles, then go to IDLE. req is ignored during GAP.
- Latency: req rising in IDLE → cs_n low on the next edge → spi_start SETUP_CYC+1 clocks after cs_n falls (busy=0).
- Boundary conditions:
  - req with no valid index is impossible by construction.
  - spi_done outside WAIT is ignored.
  - Simultaneous req from all requesters: served in strict rotation.
  - A single requester re-requesting after GAP is re-granted immediately.
- Reset mid-burst: all outputs return to reset values immediately (cs_n released asynchronously); the pointer resets.
- grant, cs_n, ack, spi_start and spi_data are registered outputs.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If TIMEOUT_CYC cycles pass without spi_done, err pulses 1 for one cycle and the FSM goes to GAP. The burst is abandoned and the pointer advances.
- Without the macro: no counter, err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Single word: req[0]=1 with data 0xA5, last=1; done returned 10 clocks after start.
  - cs_n[0] low for SETUP_CYC+12 clocks.
  - One spi_start with spi_data=0xA5; ack[0] once.
  - GAP of 4 clocks, then IDLE.
- Burst of 3 from requester 2 (data 0x11, 0x22, 0x33, last on the third word): three starts with those values and cs_n[2] held low throughout. ack[2] pulses 3 times; grant=0b0100 for the whole burst.
- Contention: req=0b1111 persistently, single words each: grant sequence 0, 1, 2, 3, 0, and never two cs_n low at once.
- busy stall: spi_busy=1 held 5 clocks on ISSUE entry. spi_start delayed exactly until the cycle after busy falls; no ack before then.
- Reset mid-burst: a_rst_n low during WAIT of word 2. cs_n goes to 0b1111 and grant to 0 asynchronously. After release, req[0] is granted first.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYC=16 and no spi_done: err pulses once 16 clocks into WAIT; cs_n is released; the next requester is granted after GAP.
